// File: rtl/rv32_muldiv_if.sv
// Execute-stage port bundle for the RV32M multiply/divide unit.
// The master side is the pipeline/hazard logic and the slave side is the unit.
interface rv32_muldiv_if;
  logic        stall_in;
  logic        flush_in;
  logic        valid_in;
  logic [2:0]  op_in;
  logic [31:0] rs1_value_in;
  logic [31:0] rs2_value_in;
  logic [4:0]  rd_in;
  logic        rd_writeback_in;
  logic        busy_out;
  logic [31:0] result_out;
  logic [4:0]  rd_out;
  logic        rd_writeback_out;

  modport master (
    output stall_in, flush_in, valid_in, op_in, rs1_value_in, rs2_value_in,
           rd_in, rd_writeback_in,
    input  busy_out, result_out, rd_out, rd_writeback_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in, op_in, rs1_value_in, rs2_value_in,
           rd_in, rd_writeback_in,
    output busy_out, result_out, rd_out, rd_writeback_out
  );
endinterface

// File: rtl/rv32_muldiv.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and restoring
// divide on operand magnitudes, sign fixup at the end, one registered beat out.
module rv32_muldiv (
  input  logic           clk,
  input  logic           reset_n,
  rv32_muldiv_if.slave   bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*XLEN-1:0]   acc_q;   // mul: {partial hi, multiplier}; div: {remainder, dividend->quotient}
  logic [XLEN-1:0]     opb_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]     res_q;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic                neg_q_q; // negate product / quotient
  logic                neg_r_q; // negate remainder

  logic                capture_c, calc_c, finish_c, deliver_c;

  // Operand decode for the incoming instruction
  logic                is_div, rs1_signed, rs2_signed, s1, s2;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     mag1, mag2, special_res;

  always_comb begin
    is_div     = bus.op_in[2];
    rs1_signed = (bus.op_in == OP_MUL) || (bus.op_in == OP_MULH) || (bus.op_in == OP_MULHSU) ||
                 (bus.op_in == OP_DIV) || (bus.op_in == OP_REM);
    rs2_signed = (bus.op_in == OP_MUL) || (bus.op_in == OP_MULH) ||
                 (bus.op_in == OP_DIV) || (bus.op_in == OP_REM);
    s1         = rs1_signed && bus.rs1_value_in[XLEN-1];
    s2         = rs2_signed && bus.rs2_value_in[XLEN-1];
    mag1       = s1 ? (~bus.rs1_value_in + XLEN'(1)) : bus.rs1_value_in;
    mag2       = s2 ? (~bus.rs2_value_in + XLEN'(1)) : bus.rs2_value_in;
    div_zero   = is_div && (bus.rs2_value_in == '0);
    div_ovf    = ((bus.op_in == OP_DIV) || (bus.op_in == OP_REM)) &&
                 (bus.rs1_value_in == 32'h8000_0000) && (bus.rs2_value_in == 32'hFFFF_FFFF);
    special    = div_zero || div_ovf;
    // op_in[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = bus.op_in[1] ? bus.rs1_value_in : 32'hFFFF_FFFF;
    else          special_res = bus.op_in[1] ? 32'h0000_0000    : 32'h8000_0000;
  end

  // One iteration of either algorithm, plus the sign fixup of its outcome
  logic [XLEN:0]       madd;
  logic [XLEN:0]       shifted;
  logic [XLEN+1:0]     diff;
  logic [2*XLEN-1:0]   mul_nxt, div_nxt, acc_nxt, prod;
  logic [XLEN-1:0]     quo, rem, fixed;

  always_comb begin
    madd    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : (XLEN+1)'(0));
    mul_nxt = {madd, acc_q[XLEN-1:1]};

    shifted = {acc_q[2*XLEN-2:XLEN], acc_q[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opb_q};
    if (!diff[XLEN+1]) div_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else               div_nxt = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    acc_nxt = op_q[2] ? div_nxt : mul_nxt;

    prod  = neg_q_q ? (~acc_nxt + (2*XLEN)'(1)) : acc_nxt;
    quo   = neg_q_q ? (~acc_nxt[XLEN-1:0] + XLEN'(1)) : acc_nxt[XLEN-1:0];
    rem   = neg_r_q ? (~acc_nxt[2*XLEN-1:XLEN] + XLEN'(1)) : acc_nxt[2*XLEN-1:XLEN];

    fixed = prod[XLEN-1:0];
    case (op_q)
      OP_MUL:                        fixed = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fixed = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fixed = quo;
      OP_REM, OP_REMU:               fixed = rem;
      default:                       fixed = prod[XLEN-1:0];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-cycle control; flush overrides everything, including stall
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    calc_c    = 1'b0;
    finish_c  = 1'b0;
    deliver_c = 1'b0;
    if (bus.flush_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_CALC: begin
          calc_c = 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            finish_c = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.stall_in) begin
            deliver_c = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: begin
          if (bus.valid_in) begin
            capture_c = 1'b1;
            state_d   = special ? S_DONE : S_CALC;
          end
        end
      endcase
    end
  end

  assign bus.busy_out = bus.valid_in && (state_q != S_DONE);

  // Datapath and the output beat register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q                <= '0;
      acc_q                <= '0;
      opb_q                <= '0;
      res_q                <= '0;
      op_q                 <= '0;
      rd_q                 <= '0;
      neg_q_q              <= 1'b0;
      neg_r_q              <= 1'b0;
      bus.result_out       <= '0;
      bus.rd_out           <= '0;
      bus.rd_writeback_out <= 1'b0;
    end else begin
      if (capture_c) begin
        op_q    <= bus.op_in;
        rd_q    <= bus.rd_in;
        cnt_q   <= '0;
        neg_q_q <= s1 ^ s2;
        neg_r_q <= s1;
        acc_q   <= {XLEN'(0), (is_div ? mag1 : mag2)};
        opb_q   <= is_div ? mag2 : mag1;
        res_q   <= special_res;
      end
      if (calc_c) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
        if (finish_c) res_q <= fixed;
      end
      if (bus.flush_in) begin
        bus.rd_writeback_out <= 1'b0;
      end else if (!bus.stall_in) begin
        bus.rd_writeback_out <= deliver_c ? bus.rd_writeback_in : 1'b0;
        if (deliver_c) begin
          bus.result_out <= res_q;
          bus.rd_out     <= rd_q;
        end
      end
    end
  end
endmodule
